// File: rtl/rom_image_loader.sv
// rom_image_loader
//   Writable counterpart of the 4K x 8 ROM lookup. A loader (UART receiver,
//   bench, ...) streams bytes in over a valid/ready handshake. They are
//   written to consecutive addresses starting at a programmable base, and
//   the address wraps modulo the memory depth. The read side keeps the ROM
//   shape: an address goes in and mem[rd_addr] comes out combinationally.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse that begins a load (honoured only in IDLE)
//   abort      cancels a load in progress (no done pulse)
//   base_addr  first write address, sampled on start
//   length     byte count 0..2**ADDR_W, sampled on start
//   in_valid   in_data holds a byte
//   in_data    byte to write
//   in_ready   loader accepts a byte this cycle (decoded from state only)
//   busy       high while loading
//   done       one-cycle pulse when a load completes
//   wrapped    sticky: the write address rolled over during the current/last load
//   wr_count   bytes written in the current/last load
//   rd_addr    read address
//   rd_data    mem[rd_addr], combinational
module rom_image_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   wr_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] wa_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   wr_count_reg;
  logic              wrapped_reg;

  // Memory contents are intentionally left uninitialised by reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic            xfer;
  logic            start_ok;
  logic            last_xfer;
  logic [ADDR_W:0] count_inc;

  // in_ready comes from the output decode of the state register, so the
  // handshake never combinationally depends on in_valid.
  assign xfer      = in_valid && in_ready;
  assign start_ok  = (state_reg == S_IDLE) && start;
  assign count_inc = wr_count_reg + CNT_ONE;
  assign last_xfer = xfer && (count_inc == len_reg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Abort takes priority over a completing transfer:
  // the byte is still written, but the load ends as cancelled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (length == CNT_ZERO) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (last_xfer) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Write address, length and status registers. start_ok and xfer are
  // mutually exclusive because xfer needs the LOAD state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_reg       <= '0;
      len_reg      <= '0;
      wr_count_reg <= '0;
      wrapped_reg  <= 1'b0;
    end else if (start_ok) begin
      wa_reg       <= base_addr;
      len_reg      <= length;
      wr_count_reg <= '0;
      wrapped_reg  <= 1'b0;
    end else if (xfer) begin
      wa_reg       <= wa_reg + 1'b1;
      wr_count_reg <= count_inc;
      if (wa_reg == ADDR_TOP) begin
        wrapped_reg <= 1'b1;
      end
    end
  end

  // Memory write port (no reset: contents survive rst_n)
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wa_reg] <= in_data;
    end
  end

  // ROM-shaped combinational read, no write-through bypass
  assign rd_data  = mem[rd_addr];
  assign wr_count = wr_count_reg;
  assign wrapped  = wrapped_reg;

endmodule

// File: tb/tb_rom_image_loader.sv
// tb_rom_image_loader
//   Directed and randomized loads against a transaction-level model of the
//   loader: a byte array plus "next address / bytes wanted / bytes taken".
//   A negedge process compares every DUT output with the model each cycle;
//   directed loads additionally pin literal values.
module tb_rom_image_loader;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length    = '0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [AW-1:0] rd_addr   = '0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          wrapped;
  logic [AW:0]   wr_count;
  logic [DW-1:0] rd_data;

  rom_image_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .base_addr(base_addr),
    .length   (length),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .wrapped  (wrapped),
    .wr_count (wr_count),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_written [DEPTH];
  bit            m_accepting;
  bit            m_done_pulse;
  bit            m_wrapped;
  int            m_next_addr;
  int            m_target;
  int            m_count;

  int n_cmp = 0;
  int n_err = 0;

  int cyc_n         = 0;
  int done_cnt      = 0;
  int ready_cnt     = 0;
  int last_xfer_cyc = -1;
  int done_cyc      = -1;

  logic [DW-1:0] data_q[$];
  bit            vpat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the loader, described as a transaction:
  // an accepted byte lands at the next address; a load ends when all
  // requested bytes are taken (done) or when cancelled (no done).
  task automatic model_step();
    bit idle;
    bit take;
    bit fin;
    idle = !m_accepting && !m_done_pulse;
    take = m_accepting && in_valid;
    fin  = 1'b0;
    if (take) begin
      m_mem[m_next_addr]     = in_data;
      m_written[m_next_addr] = 1'b1;
      if (m_next_addr == DEPTH - 1) m_wrapped = 1'b1;
      m_next_addr = (m_next_addr + 1) % DEPTH;
      m_count++;
    end
    if (m_accepting) begin
      if (abort) begin
        m_accepting = 1'b0;
      end else if (take && m_count == m_target) begin
        m_accepting = 1'b0;
        fin = 1'b1;
      end
    end else if (idle && start) begin
      m_next_addr = int'(base_addr);
      m_target    = int'(length);
      m_count     = 0;
      m_wrapped   = 1'b0;
      if (length == 0) fin = 1'b1;
      else m_accepting = 1'b1;
    end
    m_done_pulse = fin;
  endtask

  initial begin
    m_accepting  = 1'b0;
    m_done_pulse = 1'b0;
    m_wrapped    = 1'b0;
    m_next_addr  = 0;
    m_target     = 0;
    m_count      = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_accepting  = 1'b0;
        m_done_pulse = 1'b0;
        m_wrapped    = 1'b0;
        m_next_addr  = 0;
        m_target     = 0;
        m_count      = 0;
      end else begin
        model_step();
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Per-cycle comparison, away from the active edge
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_accepting});
      check("busy",     {31'd0, busy},     {31'd0, m_accepting});
      check("done",     {31'd0, done},     {31'd0, m_done_pulse});
      check("wrapped",  {31'd0, wrapped},  {31'd0, m_wrapped});
      check("wr_count", {19'd0, wr_count}, m_count);
      if (m_written[rd_addr]) check("rd_data", {24'd0, rd_data}, {24'd0, m_mem[rd_addr]});
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      if (in_ready) begin
        ready_cnt++;
        if (in_valid) last_xfer_cyc = cyc_n + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_addr = a;
    #1;
    check(name, {24'd0, rd_data}, {24'd0, e});
  endtask

  // Runs one load. vpat_q (if non-empty) gives in_valid per cycle, otherwise
  // in_valid is random with vpct percent. abort_at >= 0 raises abort along
  // with that transfer; reset_at >= 0 pulls rst_n low between edges after
  // that many transfers; restart pulses a second start mid-load.
  task automatic do_load(input logic [AW-1:0] b, input logic [AW:0] l, input int vpct,
                         input int abort_at, input bit restart, input int reset_at);
    int   idx   = 0;
    int   xfers = 0;
    int   iter  = 0;
    logic rdy;
    bit   v;
    bit   stop  = 1'b0;
    done_cnt      = 0;
    ready_cnt     = 0;
    last_xfer_cyc = -1;
    done_cyc      = -1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    cyc();
    start     = 1'b0;
    base_addr = AW'($urandom_range(DEPTH - 1));
    length    = (AW + 1)'($urandom_range(2 * DEPTH - 1));
    while (busy && !stop) begin
      if (iter >= 20000) begin
        n_cmp++;
        n_err++;
        $display("FAIL load_timeout: got busy after %0d cycles, expected load to finish", iter);
        break;
      end
      iter++;
      rdy = in_ready;
      if (vpat_q.size() > 0) v = vpat_q.pop_front();
      else v = ($urandom_range(99) < vpct);
      in_valid = v;
      in_data  = (idx < data_q.size()) ? data_q[idx] : DW'($urandom);
      abort    = (abort_at >= 0) && (xfers == abort_at) && v;
      if (restart && iter == 2) begin
        start     = 1'b1;
        base_addr = 12'h300;
        length    = 13'd9;
      end
      if ($urandom_range(1) == 1) rd_addr = AW'((m_next_addr + DEPTH - 1) % DEPTH);
      else rd_addr = AW'($urandom_range(DEPTH - 1));
      cyc();
      start    = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      if (v && rdy) begin
        idx++;
        xfers++;
      end
      if (abort_at >= 0 && xfers > abort_at) stop = 1'b1;
      if (reset_at >= 0 && xfers == reset_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_wr_count", {19'd0, wr_count}, 32'd0);
        check("rst_wrapped",  {31'd0, wrapped},  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stop = 1'b1;
      end
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    $display("load base=0x%03h len=%0d accepted=%0d wr_count=%0d wrapped=%0b done_pulses=%0d",
             b, l, xfers, wr_count, wrapped, done_cnt);
  endtask

  // Watchdog: the run must never hang
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] rb;
    logic [AW:0]   rl;
    int            ra;

    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    check("reset_done",     {31'd0, done},     32'd0);
    check("reset_wrapped",  {31'd0, wrapped},  32'd0);
    check("reset_wr_count", {19'd0, wr_count}, 32'd0);

    // Basic load
    data_q.delete();
    for (int i = 0; i < 11; i++) data_q.push_back(DW'(8'h10 + i));
    do_load(12'h000, 13'd11, 100, -1, 1'b0, -1);
    check("basic_ready_cycles", ready_cnt, 32'd11);
    check("basic_done_pulses",  done_cnt,  32'd1);
    check("basic_wr_count",     {19'd0, wr_count}, 32'd11);
    check("basic_wrapped",      {31'd0, wrapped},  32'd0);
    for (int i = 0; i < 11; i++) read_check("basic_mem", AW'(i), DW'(8'h10 + i));

    // Throttled handshake
    data_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_load(12'h100, 13'd4, 100, -1, 1'b0, -1);
    check("throttle_ready_cycles", ready_cnt, 32'd7);
    check("throttle_done_pulses",  done_cnt,  32'd1);
    check("throttle_done_timing",  done_cyc,  last_xfer_cyc);
    check("throttle_wr_count",     {19'd0, wr_count}, 32'd4);
    for (int i = 0; i < 4; i++) read_check("throttle_mem", AW'(12'h100 + i), DW'(8'hA1 + i));

    // Wrap
    data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_load(12'hFFE, 13'd4, 100, -1, 1'b0, -1);
    check("wrap_wrapped", {31'd0, wrapped}, 32'd1);
    read_check("wrap_mem_ffe", 12'hFFE, 8'h01);
    read_check("wrap_mem_fff", 12'hFFF, 8'h02);
    read_check("wrap_mem_000", 12'h000, 8'h03);
    read_check("wrap_mem_001", 12'h001, 8'h04);

    // Zero length
    data_q.delete();
    do_load(12'h555, 13'd0, 100, -1, 1'b0, -1);
    check("zero_done_pulses",  done_cnt,  32'd1);
    check("zero_ready_cycles", ready_cnt, 32'd0);
    check("zero_wr_count",     {19'd0, wr_count}, 32'd0);
    check("zero_wrapped",      {31'd0, wrapped},  32'd0);

    // Second start during a 3-byte load is ignored
    data_q = '{8'hC1, 8'hC2, 8'hC3};
    do_load(12'h200, 13'd3, 100, -1, 1'b1, -1);
    check("restart_wr_count",    {19'd0, wr_count}, 32'd3);
    check("restart_done_pulses", done_cnt, 32'd1);
    for (int i = 0; i < 3; i++) read_check("restart_mem", AW'(12'h200 + i), DW'(8'hC1 + i));

    // Abort together with the 4th transfer
    data_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    do_load(12'h020, 13'd8, 100, 3, 1'b0, -1);
    check("abort_done_pulses", done_cnt, 32'd0);
    check("abort_wr_count",    {19'd0, wr_count}, 32'd4);
    check("abort_busy",        {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) read_check("abort_mem", AW'(12'h020 + i), DW'(8'h55 + 8'h11 * i));

    // Asynchronous reset mid-load
    data_q.delete();
    for (int i = 0; i < 20; i++) data_q.push_back(DW'(8'hD0 + i));
    do_load(12'h400, 13'd20, 100, -1, 1'b0, 5);
    for (int i = 0; i < 5; i++) read_check("reset_keep_mem", AW'(12'h400 + i), DW'(8'hD0 + i));

    // Randomized loads against the model
    data_q.delete();
    for (int n = 0; n < 30; n++) begin
      rb = AW'($urandom_range(DEPTH - 1));
      ra = $urandom_range(9);
      if (ra == 0) rl = '0;
      else if (ra < 3) rl = (AW + 1)'(DEPTH - int'(rb) + int'($urandom_range(1, 20)));
      else rl = (AW + 1)'($urandom_range(1, 300));
      if (rl > (AW + 1)'(DEPTH)) rl = (AW + 1)'(DEPTH);
      do_load(rb, rl, int'($urandom_range(30, 100)),
              ($urandom_range(4) == 0 && rl != 0) ? int'($urandom_range(0, int'(rl) - 1)) : -1,
              1'b0, -1);
      // Idle gap: abort has no effect here, and reads sweep the memory
      for (int k = 0; k < 4; k++) begin
        abort   = 1'($urandom_range(1));
        rd_addr = AW'($urandom_range(DEPTH - 1));
        cyc();
      end
      abort = 1'b0;
    end

    // Full-memory load
    rb = AW'($urandom_range(1, DEPTH - 1));
    do_load(rb, 13'd4096, 100, -1, 1'b0, -1);
    check("full_wr_count", {19'd0, wr_count}, 32'd4096);
    check("full_wrapped",  {31'd0, wrapped},  32'd1);
    for (int k = 0; k < 64; k++) begin
      rd_addr = AW'($urandom_range(DEPTH - 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
